spi_master: RTL and testbench

- SPI mode-0 master that is the initiating end for the team's spi_slave.
- Serialises a parallel word onto mosi MSB-first, generates sclk and cs_n, and captures miso into a parallel word.
- Sits between a local controller (start/done handshake) and the off-block SPI pins, running on one system clock.

---
 rtl/spi_master.sv | 114 +++++++++++
 tb/tb_spi_master.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI mode-0 master: shifts a parallel word out on mosi MSB-first, drives sclk/cs_n,
// and assembles miso into rx_data. Every output is a register.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | cs_n high, waiting for start
// LEAD    | cs_n low, sclk low; setup time before the first rising edge
// SCLK_HI | sclk high; miso was sampled on entry
// SCLK_LO | sclk low between bits; mosi moved to the next bit on entry
// TRAIL   | sclk low after the last bit; cs_n hold time before release
module spi_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  done,
  output logic                  sclk,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  cs_n
);

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] DIV_M1 = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST   = BW'(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, LEAD, SCLK_HI, SCLK_LO, TRAIL} state_t;

  state_t                state;
  logic [CW-1:0]         half_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] tx_sh;
  logic [DATA_WIDTH-1:0] rx_sh;

  // mosi is the top bit of the transmit shift register, so it is registered and
  // only moves when that register shifts (E0 load or an sclk falling transition).
  assign mosi = tx_sh[DATA_WIDTH-1];

  // Sequencer: half-period down-counter reloads on every state change; bit_cnt
  // counts rising sclk edges issued so far.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      half_cnt <= '0;
      bit_cnt  <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sclk     <= 1'b0;
      cs_n     <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_sh    <= tx_data;
            cs_n     <= 1'b0;
            busy     <= 1'b1;
            bit_cnt  <= '0;
            half_cnt <= DIV_M1;
            state    <= LEAD;
          end
        end
        LEAD, SCLK_LO: begin
          if (half_cnt == '0) begin
            sclk     <= 1'b1;
            rx_sh    <= {rx_sh[DATA_WIDTH-2:0], miso};
            bit_cnt  <= bit_cnt + BW'(1);
            half_cnt <= DIV_M1;
            state    <= SCLK_HI;
          end else begin
            half_cnt <= half_cnt - CW'(1);
          end
        end
        SCLK_HI: begin
          if (half_cnt == '0) begin
            sclk     <= 1'b0;
            half_cnt <= DIV_M1;
            if (bit_cnt == LAST) begin
              state <= TRAIL;
            end else begin
              tx_sh <= {tx_sh[DATA_WIDTH-2:0], 1'b0};
              state <= SCLK_LO;
            end
          end else begin
            half_cnt <= half_cnt - CW'(1);
          end
        end
        TRAIL: begin
          if (half_cnt == '0) begin
            cs_n     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
            rx_data  <= rx_sh;
            half_cnt <= '0;
            state    <= IDLE;
          end else begin
            half_cnt <= half_cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: 8-bit/CLK_DIV=2 instance with selectable
// loopback or behavioural slave on miso, plus a 16-bit/CLK_DIV=1 loopback instance.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start;
  logic [7:0] tx_data, rx_data;
  logic       busy, done, sclk, mosi, miso, cs_n;

  logic       use_slave;
  logic [7:0] sl_word, sl_tx, sl_rx;
  logic       sl_miso;

  logic        start16;
  logic [15:0] tx16, rx16;
  logic        busy16, done16, sclk16, mosi16, cs16;

  assign miso = use_slave ? sl_miso : mosi;

  spi_master #(.DATA_WIDTH(8), .CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .rx_data(rx_data),
    .busy(busy), .done(done), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  spi_master #(.DATA_WIDTH(16), .CLK_DIV(1)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .tx_data(tx16), .rx_data(rx16),
    .busy(busy16), .done(done16), .sclk(sclk16), .mosi(mosi16), .miso(mosi16), .cs_n(cs16)
  );

  // Behavioural mode-0 slave: MSB ready at cs_n fall, next bit after each sclk fall,
  // captures mosi on sclk rise.
  always @(negedge cs_n) begin
    sl_tx   = sl_word;
    sl_miso = sl_word[7];
  end
  always @(negedge sclk) begin
    if (!cs_n) begin
      sl_tx   = {sl_tx[6:0], 1'b0};
      sl_miso = sl_tx[7];
    end
  end
  always @(posedge sclk) sl_rx = {sl_rx[6:0], mosi};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Launch one 8-bit transfer and follow it to done (bounded). Optional extra start
  // pulses with tx_data=FF at cycles p1/p2 after the accepting edge.
  task automatic xfer(input logic [7:0] tx, input int p1, input int p2,
                      output int lat, output int rises, output int cslow,
                      output logic [7:0] mword);
    logic prev;
    @(negedge clk);
    start   = 1'b1;
    tx_data = tx;
    @(posedge clk); #1;
    start = 1'b0;
    chk("accept_cs_n_low", {31'd0, cs_n}, 32'd0);
    lat = 0; rises = 0; cslow = 0; mword = 8'h00;
    prev = sclk;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      lat = k;
      if (sclk && !prev) begin
        rises++;
        mword = {mword[6:0], mosi};
      end
      prev = sclk;
      if (done) break;
      if (!cs_n) cslow++;
      start = (k == p1 || k == p2);
      if (start) tx_data = 8'hFF;
    end
    start = 1'b0;
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       slave;
    logic [7:0] sword;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int lat, rises, cslow, nd, n, m, tog;
    logic [7:0] mword;
    logic prev;

    vecs[0] = '{tx: 8'hA5, slave: 1'b0, sword: 8'h00, exp_rx: 8'hA5};
    vecs[1] = '{tx: 8'hCC, slave: 1'b1, sword: 8'hAA, exp_rx: 8'hAA};
    vecs[2] = '{tx: 8'h3C, slave: 1'b0, sword: 8'h00, exp_rx: 8'h3C};
    vecs[3] = '{tx: 8'h81, slave: 1'b1, sword: 8'h5E, exp_rx: 8'h5E};

    rst = 1'b1; start = 1'b0; tx_data = 8'h00; use_slave = 1'b0;
    sl_word = 8'h00; sl_tx = 8'h00; sl_rx = 8'h00; sl_miso = 1'b0;
    start16 = 1'b0; tx16 = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("rst_mosi", {31'd0, mosi}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rx",   {24'd0, rx_data}, 32'd0);
    rst = 1'b0;

    // Table: loopback and slave-model transfers
    for (int i = 0; i < 4; i++) begin
      use_slave = vecs[i].slave;
      sl_word   = vecs[i].sword;
      sl_rx     = 8'h00;
      xfer(vecs[i].tx, 0, 0, lat, rises, cslow, mword);
      chk("vec_latency", lat, 34);
      chk("vec_rises", rises, 8);
      chk("vec_cs_low", cslow, 33);
      chk("vec_rx", {24'd0, rx_data}, {24'd0, vecs[i].exp_rx});
      chk("vec_slave_rx", {24'd0, sl_rx}, {24'd0, vecs[i].tx});
      chk("vec_mosi_word", {24'd0, mword}, {24'd0, vecs[i].tx});
      count_done(5, nd);
      chk("vec_done_once", nd, 0);
    end
    use_slave = 1'b0;

    // start pulses while busy are ignored
    xfer(8'h3C, 5, 20, lat, rises, cslow, mword);
    chk("ign_latency", lat, 34);
    chk("ign_mosi_word", {24'd0, mword}, 32'h3C);
    chk("ign_rx", {24'd0, rx_data}, 32'h3C);
    count_done(40, nd);
    chk("ign_no_extra_done", nd, 0);
    chk("ign_idle", {31'd0, busy}, 32'd0);

    // reset mid-transfer
    @(negedge clk);
    start = 1'b1; tx_data = 8'hC3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_sclk", {31'd0, sclk}, 32'd0);
    chk("mid_rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_rx", {24'd0, rx_data}, 32'd0);
    count_done(40, nd);
    chk("mid_rst_no_done", nd, 0);
    xfer(8'h5A, 0, 0, lat, rises, cslow, mword);
    chk("post_rst_latency", lat, 34);
    chk("post_rst_rx", {24'd0, rx_data}, 32'h5A);

    // back-to-back with start held high
    @(negedge clk);
    start = 1'b1; tx_data = 8'h12;
    @(posedge clk); #1;
    tx_data = 8'h34;
    n = 200;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (done) begin n = k; break; end
    end
    chk("b2b_lat1", n, 34);
    chk("b2b_rx1", {24'd0, rx_data}, 32'h12);
    chk("b2b_cs_high", {31'd0, cs_n}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_cs_relow", {31'd0, cs_n}, 32'd0);
    chk("b2b_busy2", {31'd0, busy}, 32'd1);
    m = 200;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (done) begin m = k; break; end
    end
    chk("b2b_lat2", m, 34);
    chk("b2b_rx2", {24'd0, rx_data}, 32'h34);

    // 16-bit, CLK_DIV=1 loopback
    @(negedge clk);
    start16 = 1'b1; tx16 = 16'hBEEF;
    @(posedge clk); #1;
    start16 = 1'b0;
    prev = sclk16; tog = 0; rises = 0; lat = 200;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (sclk16 != prev) tog++;
      if (sclk16 && !prev) rises++;
      prev = sclk16;
      if (done16) begin lat = k; break; end
    end
    chk("w16_latency", lat, 33);
    chk("w16_toggles", tog, 32);
    chk("w16_rises", rises, 16);
    chk("w16_rx", {16'd0, rx16}, 32'hBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
